// File: rtl/min_sec_counter.sv
// Minutes:seconds BCD time-of-day counter (00:00-59:59) with a one-second prescaler.
// Optional load/validate path compiled in by MIN_SEC_COUNTER_TIME_SET_EN.
module min_sec_counter #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned DIV_W    = 26
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       run_i,
  input  logic       clr_i,
`ifdef MIN_SEC_COUNTER_TIME_SET_EN
  input  logic       set_load_i,
  input  logic [7:0] set_min_i,
  input  logic [7:0] set_sec_i,
`endif
  output logic [7:0] seconds_o,
  output logic [7:0] minutes_o,
  output logic       sec_tick_o,
  output logic       hour_inc_o,
  output logic       set_err_o
);

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [3:0]       sec_u_q, sec_u_d;
  logic [3:0]       sec_t_q, sec_t_d;
  logic [3:0]       min_u_q, min_u_d;
  logic [3:0]       min_t_q, min_t_d;
  logic             sec_tick_q, sec_tick_d;
  logic             hour_inc_q, hour_inc_d;
  logic             set_err_q, set_err_d;

  logic             tick;
  logic             load_ok;
  logic             load_bad;
  logic [7:0]       ld_min;
  logic [7:0]       ld_sec;

  // Load request decode; in the default build time changes only by tick, clr and reset.
`ifdef MIN_SEC_COUNTER_TIME_SET_EN
  logic fields_ok;
  assign fields_ok = (set_min_i[7:4] <= 4'd5) && (set_min_i[3:0] <= 4'd9) &&
                     (set_sec_i[7:4] <= 4'd5) && (set_sec_i[3:0] <= 4'd9);
  assign load_ok  = set_load_i &&  fields_ok;
  assign load_bad = set_load_i && !fields_ok;
  assign ld_min   = set_min_i;
  assign ld_sec   = set_sec_i;
`else
  assign load_ok  = 1'b0;
  assign load_bad = 1'b0;
  assign ld_min   = 8'h00;
  assign ld_sec   = 8'h00;
`endif

  assign tick = (state_q == RUN) && (presc_q == PRESC_MAX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= STOP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STOP:    if (run_i)  state_d = RUN;
      RUN:     if (!run_i) state_d = STOP;
      default: state_d = STOP;
    endcase
  end

  // Priority: clr, then an accepted load, then a rejected load (which freezes the
  // cycle so a pending tick is only delayed), then normal counting in RUN.
  always_comb begin
    presc_d    = presc_q;
    sec_u_d    = sec_u_q;
    sec_t_d    = sec_t_q;
    min_u_d    = min_u_q;
    min_t_d    = min_t_q;
    sec_tick_d = 1'b0;
    hour_inc_d = 1'b0;
    set_err_d  = 1'b0;
    if (clr_i) begin
      presc_d = '0;
      sec_u_d = 4'd0;
      sec_t_d = 4'd0;
      min_u_d = 4'd0;
      min_t_d = 4'd0;
    end else if (load_ok) begin
      presc_d = '0;
      sec_u_d = ld_sec[3:0];
      sec_t_d = ld_sec[7:4];
      min_u_d = ld_min[3:0];
      min_t_d = ld_min[7:4];
    end else if (load_bad) begin
      set_err_d = 1'b1;
    end else if (state_q == RUN) begin
      if (tick) begin
        presc_d    = '0;
        sec_tick_d = 1'b1;
        if (sec_u_q < 4'd9) begin
          sec_u_d = sec_u_q + 4'd1;
        end else begin
          sec_u_d = 4'd0;
          if (sec_t_q < 4'd5) begin
            sec_t_d = sec_t_q + 4'd1;
          end else begin
            sec_t_d = 4'd0;
            if (min_u_q < 4'd9) begin
              min_u_d = min_u_q + 4'd1;
            end else begin
              min_u_d = 4'd0;
              if (min_t_q < 4'd5) begin
                min_t_d = min_t_q + 4'd1;
              end else begin
                min_t_d    = 4'd0;
                hour_inc_d = 1'b1;
              end
            end
          end
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q    <= '0;
      sec_u_q    <= 4'd0;
      sec_t_q    <= 4'd0;
      min_u_q    <= 4'd0;
      min_t_q    <= 4'd0;
      sec_tick_q <= 1'b0;
      hour_inc_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sec_u_q    <= sec_u_d;
      sec_t_q    <= sec_t_d;
      min_u_q    <= min_u_d;
      min_t_q    <= min_t_d;
      sec_tick_q <= sec_tick_d;
      hour_inc_q <= hour_inc_d;
      set_err_q  <= set_err_d;
    end
  end

  assign seconds_o  = {sec_t_q, sec_u_q};
  assign minutes_o  = {min_t_q, min_u_q};
  assign sec_tick_o = sec_tick_q;
  assign hour_inc_o = hour_inc_q;
  assign set_err_o  = set_err_q;

  logic digits_ok;
  assign digits_ok = (sec_u_q <= 4'd9) && (sec_t_q <= 4'd5) &&
                     (min_u_q <= 4'd9) && (min_t_q <= 4'd5);

  assert property (@(posedge clk_i) disable iff (!rst_ni) digits_ok);

endmodule

// File: tb/tb_min_sec_counter.sv
// Directed bench for min_sec_counter: two instances (TICK_DIV=4 and TICK_DIV=1)
// checked every cycle against an integer seconds-of-hour model.
module tb_min_sec_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4_n, run4, clr4;
  logic [7:0] sec4, min4;
  logic       tick4, hour4, err4;
  logic       rst1_n, run1, clr1;
  logic [7:0] sec1, min1;
  logic       tick1, hour1, err1;
`ifdef MIN_SEC_COUNTER_TIME_SET_EN
  logic       ld4, ld1;
  logic [7:0] lmin4, lsec4, lmin1, lsec1;
`endif

  min_sec_counter #(.TICK_DIV(4), .DIV_W(2)) dut4 (
    .clk_i(clk), .rst_ni(rst4_n), .run_i(run4), .clr_i(clr4),
`ifdef MIN_SEC_COUNTER_TIME_SET_EN
    .set_load_i(ld4), .set_min_i(lmin4), .set_sec_i(lsec4),
`endif
    .seconds_o(sec4), .minutes_o(min4), .sec_tick_o(tick4),
    .hour_inc_o(hour4), .set_err_o(err4)
  );

  min_sec_counter #(.TICK_DIV(1), .DIV_W(1)) dut1 (
    .clk_i(clk), .rst_ni(rst1_n), .run_i(run1), .clr_i(clr1),
`ifdef MIN_SEC_COUNTER_TIME_SET_EN
    .set_load_i(ld1), .set_min_i(lmin1), .set_sec_i(lsec1),
`endif
    .seconds_o(sec1), .minutes_o(min1), .sec_tick_o(tick1),
    .hour_inc_o(hour1), .set_err_o(err1)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Model: time is an integer count of seconds within the hour.
  int m_t[2];
  int m_p[2];
  bit m_run[2], m_tk[2], m_hr[2], m_er[2];

  function automatic logic [15:0] to_bcd(input int t);
    int mm, ss;
    mm = t / 60;
    ss = t % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic bit bcd_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd5) && (b[3:0] <= 4'd9);
  endfunction

  function automatic int bcd_val(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic model_reset(input int k);
    m_t[k] = 0; m_p[k] = 0; m_run[k] = 0; m_tk[k] = 0; m_hr[k] = 0; m_er[k] = 0;
  endtask

  task automatic model_step(input int k, input int td, input bit run, input bit clr,
                            input bit ld, input logic [7:0] lm, input logic [7:0] ls);
    bit tk;
    tk = m_run[k] && (m_p[k] == td - 1);
    m_tk[k] = 0; m_hr[k] = 0; m_er[k] = 0;
    if (clr) begin
      m_t[k] = 0; m_p[k] = 0;
    end else if (ld && bcd_ok(lm) && bcd_ok(ls)) begin
      m_t[k] = bcd_val(lm) * 60 + bcd_val(ls); m_p[k] = 0;
    end else if (ld) begin
      m_er[k] = 1;
    end else if (m_run[k]) begin
      if (tk) begin
        m_p[k] = 0;
        m_t[k] = (m_t[k] + 1) % 3600;
        m_tk[k] = 1;
        m_hr[k] = (m_t[k] == 0);
      end else begin
        m_p[k] = m_p[k] + 1;
      end
    end
    m_run[k] = run;
  endtask

  always @(posedge clk or negedge rst4_n) begin
    if (!rst4_n) model_reset(0);
`ifdef MIN_SEC_COUNTER_TIME_SET_EN
    else model_step(0, 4, run4, clr4, ld4, lmin4, lsec4);
`else
    else model_step(0, 4, run4, clr4, 1'b0, 8'h00, 8'h00);
`endif
  end

  always @(posedge clk or negedge rst1_n) begin
    if (!rst1_n) model_reset(1);
`ifdef MIN_SEC_COUNTER_TIME_SET_EN
    else model_step(1, 1, run1, clr1, ld1, lmin1, lsec1);
`else
    else model_step(1, 1, run1, clr1, 1'b0, 8'h00, 8'h00);
`endif
  end

  logic [15:0] e0, e1;
  always @(negedge clk) begin
    e0 = to_bcd(m_t[0]);
    e1 = to_bcd(m_t[1]);
    check("cyc_min4", 32'(min4), 32'(e0[15:8]));
    check("cyc_sec4", 32'(sec4), 32'(e0[7:0]));
    check("cyc_tick4", 32'(tick4), 32'(m_tk[0]));
    check("cyc_hour4", 32'(hour4), 32'(m_hr[0]));
    check("cyc_err4", 32'(err4), 32'(m_er[0]));
    check("cyc_min1", 32'(min1), 32'(e1[15:8]));
    check("cyc_sec1", 32'(sec1), 32'(e1[7:0]));
    check("cyc_tick1", 32'(tick1), 32'(m_tk[1]));
    check("cyc_hour1", 32'(hour1), 32'(m_hr[1]));
    check("cyc_err1", 32'(err1), 32'(m_er[1]));
  end

  // sec_tick spacing on the TICK_DIV=4 instance during the first run.
  int  cyc = 0;
  int  np4 = 0;
  int  last4 = 0;
  bit  t_space = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (t_space && tick4) begin
      if (np4 > 0) check("tick4_spacing", 32'(cyc - last4), 32'd4);
      np4++;
      last4 = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit          found;
  bit          seen_a, seen_b, seen_w;
  int          nh;
  logic [15:0] prev;

  initial begin
    rst4_n = 0; run4 = 0; clr4 = 0;
    rst1_n = 0; run1 = 0; clr1 = 0;
`ifdef MIN_SEC_COUNTER_TIME_SET_EN
    ld4 = 0; lmin4 = 8'h00; lsec4 = 8'h00;
    ld1 = 0; lmin1 = 8'h00; lsec1 = 8'h00;
`endif
    step(3);
    check("rst_sec4", 32'(sec4), 32'h00);
    check("rst_min4", 32'(min4), 32'h00);
    check("rst_pulses4", 32'({tick4, hour4, err4}), 32'd0);
    check("rst_sec1", 32'(sec1), 32'h00);
    check("rst_min1", 32'(min1), 32'h00);

    // Sixteen RUN cycles at TICK_DIV=4 give four seconds.
    rst4_n = 1; run4 = 1; t_space = 1;
    step(16);
    run4 = 0;
    step(1);
    check("run16_sec4", 32'(sec4), 32'h04);
    step(3);
    check("stopped_sec4", 32'(sec4), 32'h04);
    check("tick4_count", 32'(np4), 32'd4);
    t_space = 0;

    // Count up to 30:15, then reset asynchronously mid-prescale.
    run4 = 1; found = 0;
    for (int i = 0; i < 8000 && !found; i++) begin
      step(1);
      if (min4 == 8'h30 && sec4 == 8'h15) found = 1;
    end
    check("reach_3015", 32'(found), 32'd1);
    step(1);
    check("mid_sec4", 32'(sec4), 32'h15);
    #2 rst4_n = 0;
    #1;
    check("async_sec4", 32'(sec4), 32'h00);
    check("async_min4", 32'(min4), 32'h00);
    check("async_pulses4", 32'({tick4, hour4, err4}), 32'd0);
    @(posedge clk); #1;
    rst4_n = 1;
    step(4);
    check("post_rst_sec4_a", 32'(sec4), 32'h00);
    step(1);
    check("post_rst_sec4_b", 32'(sec4), 32'h01);
    check("post_rst_tick4", 32'(tick4), 32'd1);
    run4 = 0;

    // TICK_DIV=1: run to 12:34, clear on a tick cycle.
    rst1_n = 1; run1 = 1; found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step(1);
      if (min1 == 8'h12 && sec1 == 8'h34) found = 1;
    end
    check("reach_1234", 32'(found), 32'd1);
    clr1 = 1;
    step(1);
    clr1 = 0;
    check("clr_time1", 32'({min1, sec1}), 32'h0000);
    check("clr_tick1", 32'(tick1), 32'd0);
    check("clr_hour1", 32'(hour1), 32'd0);

    // Full hour from 00:00: digit carries and the wrap.
    prev = 16'h0000; seen_a = 0; seen_b = 0; seen_w = 0; nh = 0;
    for (int i = 0; i < 3605; i++) begin
      step(1);
      if (hour1) nh++;
      if (prev == 16'h0009) begin
        check("carry_0009", 32'({min1, sec1}), 32'h0010); seen_a = 1;
      end
      if (prev == 16'h0959) begin
        check("carry_0959", 32'({min1, sec1}), 32'h1000); seen_b = 1;
      end
      if (prev == 16'h5959) begin
        check("wrap_time", 32'({min1, sec1}), 32'h0000);
        check("wrap_hour", 32'(hour1), 32'd1);
        seen_w = 1;
      end
      prev = {min1, sec1};
    end
    check("seen_0009", 32'(seen_a), 32'd1);
    check("seen_0959", 32'(seen_b), 32'd1);
    check("seen_wrap", 32'(seen_w), 32'd1);
    check("hour_count", 32'(nh), 32'd1);

`ifdef MIN_SEC_COUNTER_TIME_SET_EN
    // Load 59:58 while running; the load overrides the coincident tick.
    ld1 = 1; lmin1 = 8'h59; lsec1 = 8'h58;
    step(1);
    ld1 = 0;
    check("load_time", 32'({min1, sec1}), 32'h5958);
    check("load_tick", 32'(tick1), 32'd0);
    step(1);
    check("load_5959", 32'({min1, sec1}), 32'h5959);
    step(1);
    check("load_wrap", 32'({min1, sec1}), 32'h0000);
    check("load_wrap_hour", 32'(hour1), 32'd1);
    step(1);
    check("load_0001", 32'({min1, sec1}), 32'h0001);
    check("load_hour_once", 32'(hour1), 32'd0);
    run1 = 0;
    step(2);
    check("stop_0002", 32'({min1, sec1}), 32'h0002);
    ld1 = 1; lmin1 = 8'h00; lsec1 = 8'h60;
    step(1);
    ld1 = 0;
    check("bad_sec_err", 32'(err1), 32'd1);
    check("bad_sec_time", 32'({min1, sec1}), 32'h0002);
    step(1);
    check("bad_sec_err_clr", 32'(err1), 32'd0);
    ld1 = 1; lmin1 = 8'h1A; lsec1 = 8'h00;
    step(1);
    ld1 = 0;
    check("bad_min_err", 32'(err1), 32'd1);
    check("bad_min_time", 32'({min1, sec1}), 32'h0002);
    ld1 = 1; lmin1 = 8'h30; lsec1 = 8'h15;
    step(1);
    ld1 = 0;
    check("stop_load", 32'({min1, sec1}), 32'h3015);
    step(2);
    check("stop_load_hold", 32'({min1, sec1}), 32'h3015);
`endif

    step(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/min_sec_counter.md
MIN_SEC_COUNTER -- requirements
Module: min_sec_counter

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 Parameter TICK_DIV, default 50000000, SHALL set the number of clk cycles per one-second tick.
REQ-003 Parameter DIV_W, default 26, SHALL set the prescaler width; TICK_DIV-1 SHALL fit in DIV_W bits.
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 run  input  1  level; 1 = time advances, 0 = time and prescaler frozen.
REQ-007 clr  input  1  synchronous clear of prescaler, seconds and minutes.
REQ-008 set_load  input  1  one-cycle load strobe (TIME_SET_EN builds only).
REQ-009 set_min  input  8  BCD minutes to load, {tens,units} (TIME_SET_EN builds only).
REQ-010 set_sec  input  8  BCD seconds to load, {tens,units} (TIME_SET_EN builds only).
REQ-011 seconds  output  8  BCD seconds 00-59, {tens[3:0],units[3:0]}.
REQ-012 minutes  output  8  BCD minutes 00-59, {tens[3:0],units[3:0]}.
REQ-013 sec_tick  output  1  one-cycle pulse on each seconds advance.
REQ-014 hour_inc  output  1  one-cycle pulse on the 59:59 -> 00:00 wrap; drives the enable of the downstream 0-23 hours counter.
REQ-015 set_err  output  1  one-cycle pulse when a load is rejected (TIME_SET_EN builds only; else tied 0).

Function
REQ-016 An FSM SHALL have states STOP and RUN; STOP->RUN when run=1, RUN->STOP when run=0, evaluated every cycle.
REQ-017 In RUN, the prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; the wrap cycle SHALL be the tick cycle.
REQ-018 In STOP, the prescaler, seconds and minutes SHALL hold; sec_tick and hour_inc SHALL be 0.
REQ-019 On a tick, seconds units SHALL increment; units 9 -> 0 with tens +1; seconds 59 -> 00.
REQ-020 On a tick with seconds=59, minutes SHALL advance by the same BCD rule; minutes 59 -> 00.
REQ-021 sec_tick SHALL be registered and assert in the cycle after the tick, coincident with the updated seconds value.
REQ-022 hour_inc SHALL be registered and assert in the cycle after the tick that moves 59:59 to 00:00, coincident with seconds=00 and minutes=00.
REQ-023 Outputs SHALL be registered; no BCD digit SHALL ever hold a value above 9, and no tens digit above 5.
REQ-024 clr=1 SHALL zero the prescaler, seconds and minutes next cycle, suppress sec_tick and hour_inc, and override any coincident tick or load.
REQ-025 A load (TIME_SET_EN) SHALL override a coincident tick, zero the prescaler, and leave the FSM state unchanged.
REQ-026 A load SHALL be accepted in both STOP and RUN.
REQ-027 A load whose digit fields contain any units > 9 or any tens > 5 SHALL be rejected: time held, prescaler untouched, set_err pulsed next cycle.
REQ-028 A tick of 1 cycle (TICK_DIV=1) SHALL advance seconds every RUN cycle.

Reset
REQ-029 reset=0 SHALL immediately force: prescaler=0, seconds=8'h00, minutes=8'h00, sec_tick=0, hour_inc=0, set_err=0, FSM=STOP.
REQ-030 Reset asserted mid-count SHALL discard in-flight pulses; after release the first tick SHALL occur TICK_DIV cycles after RUN is entered.

Configuration
REQ-031 Macro MIN_SEC_COUNTER_TIME_SET_EN defined SHALL compile in set_load, set_min, set_sec, the load/validation logic and set_err.
REQ-032 Without MIN_SEC_COUNTER_TIME_SET_EN, the ports set_load, set_min and set_sec SHALL be absent, set_err SHALL be constant 0, and time SHALL change only by ticks, clr and reset.

Verification
REQ-033 TICK_DIV=4, reset, run=1 for 16 cycles -> seconds=8'h04, four sec_tick pulses spaced 4 cycles apart.
REQ-034 TICK_DIV=1, load 59:58, run=1 -> 59:59, then 00:00 with hour_inc=1 for exactly one cycle.
REQ-035 TICK_DIV=1, run=1 from 00:09 -> 00:10; from 09:59 -> 10:00; no digit ever reads A-F.
REQ-036 clr and tick in the same cycle at 12:34 -> 00:00, no sec_tick, no hour_inc.
REQ-037 Load set_sec=8'h60 -> set_err pulse, time unchanged; load set_min=8'h1A -> set_err pulse, time unchanged.
REQ-038 reset=0 asserted asynchronously mid-prescale at 30:15 -> outputs 0 before the next clk edge, FSM=STOP.
